// File: rtl/rv32_instr_aligner_if.sv
// Fetch-to-decode handshake bundle for the rv32 parcel aligner.
interface rv32_instr_aligner_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [31:0]   fetch_word;
  logic [31:0]   fetch_addr;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_instr;
  logic [31:0]   dec_pc;
  logic          dec_compressed;
  logic          dec_illegal;
  logic [CW-1:0] occupancy;

  modport master (
    output flush, fetch_valid, fetch_word, fetch_addr, dec_ready,
    input  fetch_ready, dec_valid, dec_instr, dec_pc, dec_compressed, dec_illegal, occupancy
  );

  modport slave (
    input  flush, fetch_valid, fetch_word, fetch_addr, dec_ready,
    output fetch_ready, dec_valid, dec_instr, dec_pc, dec_compressed, dec_illegal, occupancy
  );
endinterface

// File: rtl/rv32_instr_aligner.sv
// Parcel realignment queue: 32-bit fetch words in, whole 16/32-bit rv32 instructions out.
module rv32_instr_aligner #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          ENABLE_C = 1'b1
) (
  input  logic clk,
  input  logic rst,
  rv32_instr_aligner_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   head_pc_q, head_pc_d;

  logic [15:0]   p0, p1;
  logic          is32, head_valid, illegal, push, pop;
  logic [CW-1:0] push_n, pop_n;
  logic          unused_addr_bit;

  // Head decode: length from the low parcel, second parcel only meaningful for 32-bit.
  assign p0         = mem_q[rd_ptr_q];
  assign p1         = mem_q[rd_ptr_q + PW'(1)];
  assign is32       = (p0[1:0] == 2'b11);
  assign head_valid = is32 ? (count_q >= CW'(2)) : (count_q >= CW'(1));
  assign illegal    = (p0 == 16'h0000) || (!ENABLE_C && !is32) || (is32 && (p0[4:2] == 3'b111));

  assign bus.fetch_ready    = !rst && !bus.flush && (count_q <= CW'(DEPTH - 2));
  assign bus.dec_valid      = !rst && head_valid;
  assign bus.dec_instr      = bus.dec_valid ? (is32 ? {p1, p0} : {16'h0000, p0}) : 32'h0;
  assign bus.dec_pc         = bus.dec_valid ? head_pc_q : 32'h0;
  assign bus.dec_compressed = bus.dec_valid && !is32;
  assign bus.dec_illegal    = bus.dec_valid && illegal;
  assign bus.occupancy      = count_q;

  assign push   = bus.fetch_valid && bus.fetch_ready;
  assign pop    = bus.dec_valid && bus.dec_ready;
  assign push_n = push ? (bus.fetch_addr[1] ? CW'(1) : CW'(2)) : CW'(0);
  assign pop_n  = pop ? (is32 ? CW'(2) : CW'(1)) : CW'(0);
  assign unused_addr_bit = bus.fetch_addr[0];

  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    head_pc_d = head_pc_q;
    count_d   = count_q + push_n - pop_n;

    if (push) begin
      if (!bus.fetch_addr[1]) begin
        mem_d[wr_ptr_q]          = bus.fetch_word[15:0];
        mem_d[wr_ptr_q + PW'(1)] = bus.fetch_word[31:16];
        wr_ptr_d                 = wr_ptr_q + PW'(2);
      end else begin
        mem_d[wr_ptr_q] = bus.fetch_word[31:16];
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      // An empty queue cannot pop, so this load never races the increment below.
      if (count_q == CW'(0)) head_pc_d = {bus.fetch_addr[31:1], 1'b0};
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + (is32 ? PW'(2) : PW'(1));
      head_pc_d = head_pc_q + (is32 ? 32'd4 : 32'd2);
    end

    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
    end
  end

  // Parcel storage carries no reset; count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_rv32_instr_aligner.sv
// Scoreboard bench for rv32_instr_aligner (C-enabled instance plus a C-disabled instance).
module tb_rv32_instr_aligner;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rv32_instr_aligner_if #(.DEPTH(4)) bus_a ();
  rv32_instr_aligner_if #(.DEPTH(4)) bus_b ();

  rv32_instr_aligner #(.DEPTH(4), .ENABLE_C(1'b1)) u_dut   (.clk(clk), .rst(rst), .bus(bus_a.slave));
  rv32_instr_aligner #(.DEPTH(4), .ENABLE_C(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [31:0] instr, input logic [31:0] pc, input logic comp, input logic ill);
    exp_t e;
    e.instr = instr; e.pc = pc; e.comp = comp; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic push(input logic [31:0] word, input logic [31:0] addr);
    int n = 0;
    while (!bus_a.fetch_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("push_ready", 32'(bus_a.fetch_ready), 32'd1);
    bus_a.fetch_valid = 1'b1;
    bus_a.fetch_word  = word;
    bus_a.fetch_addr  = addr;
    tick();
    bus_a.fetch_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: every accepted instruction must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.dec_valid && bus_a.dec_ready && !bus_a.flush) begin
        if (sb.size() == 0) begin
          check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("dec_instr", bus_a.dec_instr, e.instr);
          check_eq("dec_pc", bus_a.dec_pc, e.pc);
          check_eq("dec_compressed", 32'(bus_a.dec_compressed), 32'(e.comp));
          check_eq("dec_illegal", 32'(bus_a.dec_illegal), 32'(e.ill));
        end
      end else if (!bus_a.dec_valid) begin
        check_eq("idle_zero", bus_a.dec_instr | bus_a.dec_pc |
                 {30'b0, bus_a.dec_compressed, bus_a.dec_illegal}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus_a.flush = 1'b0; bus_a.fetch_valid = 1'b0; bus_a.fetch_word = '0; bus_a.fetch_addr = '0; bus_a.dec_ready = 1'b0;
    bus_b.flush = 1'b0; bus_b.fetch_valid = 1'b0; bus_b.fetch_word = '0; bus_b.fetch_addr = '0; bus_b.dec_ready = 1'b0;
    tick(); tick();
    check_eq("rst_fetch_ready", 32'(bus_a.fetch_ready), 32'd0);
    check_eq("rst_dec_valid", 32'(bus_a.dec_valid), 32'd0);
    check_eq("rst_occupancy", 32'(bus_a.occupancy), 32'd0);
    rst = 1'b0;
    tick();

    // 1: aligned 32-bit, one-cycle latency
    bus_a.dec_ready = 1'b1;
    expect_out(32'h0000_0013, 32'h0, 1'b0, 1'b0);
    push(32'h0000_0013, 32'h0);
    check_eq("t1_latency_valid", 32'(bus_a.dec_valid), 32'd1);
    check_eq("t1_latency_pc", bus_a.dec_pc, 32'h0);
    drain("t1_drain");

    // 2: two compressed parcels in one word
    expect_out(32'h0000_4501, 32'h0, 1'b1, 1'b0);
    expect_out(32'h0000_4501, 32'h2, 1'b1, 1'b0);
    push(32'h4501_4501, 32'h0);
    drain("t2_drain");
    check_eq("t2_empty_valid", 32'(bus_a.dec_valid), 32'd0);

    // 3: straddling 32-bit held until its upper parcel arrives
    expect_out(32'h0000_4501, 32'h0, 1'b1, 1'b0);
    push(32'h0013_4501, 32'h0);
    tick(); tick(); tick();
    check_eq("t3_straddle_wait", 32'(bus_a.dec_valid), 32'd0);
    check_eq("t3_straddle_occ", 32'(bus_a.occupancy), 32'd1);
    expect_out(32'h0000_0013, 32'h2, 1'b0, 1'b0);
    expect_out(32'h0000_4501, 32'h6, 1'b1, 1'b0);
    push(32'h4501_0000, 32'h4);
    drain("t3_drain");

    // 4: full at DEPTH, unblocked one cycle after a 32-bit pop
    bus_a.dec_ready = 1'b0;
    push(32'h0000_0013, 32'h10);
    push(32'h0010_0093, 32'h14);
    check_eq("t4_occ_full", 32'(bus_a.occupancy), 32'd4);
    check_eq("t4_ready_full", 32'(bus_a.fetch_ready), 32'd0);
    expect_out(32'h0000_0013, 32'h10, 1'b0, 1'b0);
    bus_a.dec_ready = 1'b1;
    tick();
    bus_a.dec_ready = 1'b0;
    check_eq("t4_occ_after_pop", 32'(bus_a.occupancy), 32'd2);
    check_eq("t4_ready_after_pop", 32'(bus_a.fetch_ready), 32'd1);
    expect_out(32'h0010_0093, 32'h14, 1'b0, 1'b0);
    bus_a.dec_ready = 1'b1;
    drain("t4_drain");

    // 4b: DEPTH-1 parcels also blocks fetch
    bus_a.dec_ready = 1'b0;
    push(32'h4501_ABCD, 32'h22);
    check_eq("t4b_ready_one", 32'(bus_a.fetch_ready), 32'd1);
    push(32'h4501_4501, 32'h24);
    check_eq("t4b_occ_three", 32'(bus_a.occupancy), 32'd3);
    check_eq("t4b_ready_three", 32'(bus_a.fetch_ready), 32'd0);
    expect_out(32'h0000_4501, 32'h22, 1'b1, 1'b0);
    expect_out(32'h0000_4501, 32'h24, 1'b1, 1'b0);
    expect_out(32'h0000_4501, 32'h26, 1'b1, 1'b0);
    bus_a.dec_ready = 1'b1;
    drain("t4b_drain");

    // 5: flush beats a same-cycle push; next push reloads head_pc
    bus_a.dec_ready = 1'b0;
    push(32'h0000_0013, 32'h30);
    bus_a.flush = 1'b1;
    bus_a.fetch_valid = 1'b1;
    bus_a.fetch_word = 32'h1234_5678;
    bus_a.fetch_addr = 32'h40;
    #1;
    check_eq("t5_ready_flush", 32'(bus_a.fetch_ready), 32'd0);
    tick();
    bus_a.flush = 1'b0;
    bus_a.fetch_valid = 1'b0;
    check_eq("t5_occ_flushed", 32'(bus_a.occupancy), 32'd0);
    check_eq("t5_valid_flushed", 32'(bus_a.dec_valid), 32'd0);
    expect_out(32'h0000_4501, 32'h102, 1'b1, 1'b0);
    push(32'h4501_ABCD, 32'h102);
    check_eq("t5_occ_one", 32'(bus_a.occupancy), 32'd1);
    check_eq("t5_pc_reload", bus_a.dec_pc, 32'h102);
    bus_a.dec_ready = 1'b1;
    drain("t5_drain");

    // 6: illegal encodings still presented and popped
    expect_out(32'h0, 32'h0, 1'b1, 1'b1);
    expect_out(32'h0, 32'h2, 1'b1, 1'b1);
    push(32'h0000_0000, 32'h0);
    drain("t6_zero_drain");
    expect_out(32'h0000_001F, 32'h8, 1'b0, 1'b1);
    push(32'h0000_001F, 32'h8);
    drain("t6_long_drain");
    check_eq("t6_long_two_popped", 32'(bus_a.occupancy), 32'd0);

    // 6b: compressed parcel illegal without C
    bus_b.fetch_valid = 1'b1;
    bus_b.fetch_word = 32'h4501_4501;
    bus_b.fetch_addr = 32'h0;
    tick();
    bus_b.fetch_valid = 1'b0;
    check_eq("t6b_valid", 32'(bus_b.dec_valid), 32'd1);
    check_eq("t6b_illegal", 32'(bus_b.dec_illegal), 32'd1);
    check_eq("t6b_compressed", 32'(bus_b.dec_compressed), 32'd1);
    check_eq("t6b_instr", bus_b.dec_instr, 32'h0000_4501);

    // 7: reset mid-stream clears the queue and masks outputs
    bus_a.dec_ready = 1'b0;
    push(32'h0000_0013, 32'h50);
    rst = 1'b1;
    #1;
    check_eq("t7_rst_ready", 32'(bus_a.fetch_ready), 32'd0);
    check_eq("t7_rst_valid", 32'(bus_a.dec_valid), 32'd0);
    check_eq("t7_rst_instr", bus_a.dec_instr, 32'h0);
    tick();
    check_eq("t7_rst_occ", 32'(bus_a.occupancy), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("t7_post_rst_valid", 32'(bus_a.dec_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
